// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
//  Module      : pc_fetch_sequencer
//  Description : Control sequencer for the stage-1 PC incrementer datapath.
//                It arbitrates sequential fetch, hazard stalls, I-mem wait
//                states and jump/branch redirects.
//                Optional feature macro: PCSEQ_PERF_CNT_EN (perf counters).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         jump_req,
    input  logic [W-1:0] jump_target,
    input  logic         branch_req,
    input  logic [W-1:0] branch_offset,
    input  logic         imem_ready,
    output logic         imem_req,
    output logic         pc_write,
    output logic         pc_source,
    output logic         pc_add,
    output logic [W-1:0] pc_add_from_se,
    output logic [W-1:0] pc_source_from_vala,
    output logic         flush,
    output logic         redir_pending
`ifdef PCSEQ_PERF_CNT_EN
    ,
    output logic [15:0]  redir_count,
    output logic [15:0]  stall_count,
    output logic [7:0]   dropped_redir
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_PEND  = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_pend_jump;
    logic [W-1:0]   r_pend_operand;

    logic           w_redir;
    logic           w_capture;
    logic           w_dropped;
    logic           w_stall_cycle;

    assign w_redir = jump_req | branch_req;

    // Control outputs are Mealy; everything is forced low while reset is held
    // so the datapath never loads the PC during reset.
    always_comb begin
        imem_req            = 1'b0;
        pc_write            = 1'b0;
        pc_source           = 1'b0;
        pc_add              = 1'b0;
        pc_add_from_se      = '0;
        pc_source_from_vala = '0;
        flush               = 1'b0;
        redir_pending       = 1'b0;
        w_capture           = 1'b0;
        w_dropped           = 1'b0;
        w_stall_cycle       = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (w_redir) begin
                        if (imem_ready) begin
                            pc_write = 1'b1;
                            flush    = 1'b1;
                            if (jump_req) begin
                                pc_source           = 1'b1;
                                pc_source_from_vala = jump_target;
                            end else begin
                                pc_add         = 1'b1;
                                pc_add_from_se = branch_offset;
                            end
                        end else begin
                            w_capture = 1'b1;
                        end
                    end else if (imem_ready && !stall) begin
                        pc_write = 1'b1;
                    end
                    w_stall_cycle = !pc_write;
                end
                S_PEND: begin
                    imem_req      = 1'b1;
                    redir_pending = 1'b1;
                    w_dropped     = w_redir;
                    if (imem_ready) begin
                        pc_write = 1'b1;
                        flush    = 1'b1;
                        if (r_pend_jump) begin
                            pc_source           = 1'b1;
                            pc_source_from_vala = r_pend_operand;
                        end else begin
                            pc_add         = 1'b1;
                            pc_add_from_se = r_pend_operand;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_BOOT;
            r_pend_jump    <= 1'b0;
            r_pend_operand <= '0;
        end else begin
            case (r_state)
                S_BOOT: r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_capture) begin
                        r_pend_jump    <= jump_req;
                        r_pend_operand <= jump_req ? jump_target : branch_offset;
                        r_state        <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (imem_ready) begin
                        r_pend_jump    <= 1'b0;
                        r_pend_operand <= '0;
                        r_state        <= S_FETCH;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

`ifdef PCSEQ_PERF_CNT_EN
    logic [15:0] r_redir_count;
    logic [15:0] r_stall_count;
    logic [7:0]  r_dropped_redir;

    // Saturating counters; an applied redirect is exactly a cycle with flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_redir_count   <= '0;
            r_stall_count   <= '0;
            r_dropped_redir <= '0;
        end else begin
            if (flush && (r_redir_count != 16'hFFFF))
                r_redir_count <= r_redir_count + 16'd1;
            if (w_stall_cycle && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
            if (w_dropped && (r_dropped_redir != 8'hFF))
                r_dropped_redir <= r_dropped_redir + 8'd1;
        end
    end

    assign redir_count   = r_redir_count;
    assign stall_count   = r_stall_count;
    assign dropped_redir = r_dropped_redir;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_dropped | w_stall_cycle;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a behavioural stage-1 PC register.
`default_nettype none

module tb_pc_fetch_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall;
    logic         jump_req;
    logic [W-1:0] jump_target;
    logic         branch_req;
    logic [W-1:0] branch_offset;
    logic         imem_ready;
    logic         imem_req;
    logic         pc_write;
    logic         pc_source;
    logic         pc_add;
    logic [W-1:0] pc_add_from_se;
    logic [W-1:0] pc_source_from_vala;
    logic         flush;
    logic         redir_pending;
`ifdef PCSEQ_PERF_CNT_EN
    logic [15:0]  redir_count;
    logic [15:0]  stall_count;
    logic [7:0]   dropped_redir;
`endif

    logic [W-1:0] pc;
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.W(W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .stall               (stall),
        .jump_req            (jump_req),
        .jump_target         (jump_target),
        .branch_req          (branch_req),
        .branch_offset       (branch_offset),
        .imem_ready          (imem_ready),
        .imem_req            (imem_req),
        .pc_write            (pc_write),
        .pc_source           (pc_source),
        .pc_add              (pc_add),
        .pc_add_from_se      (pc_add_from_se),
        .pc_source_from_vala (pc_source_from_vala),
        .flush               (flush),
        .redir_pending       (redir_pending)
`ifdef PCSEQ_PERF_CNT_EN
        ,
        .redir_count         (redir_count),
        .stall_count         (stall_count),
        .dropped_redir       (dropped_redir)
`endif
    );

    // Stage-1 PC register following the datapath load contract.
    always @(posedge clk) begin
        if (!rst_n)
            pc <= '0;
        else if (pc_write)
            pc <= pc_source ? pc_source_from_vala :
                  pc_add    ? pc + pc_add_from_se : pc + 16'd2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        stall         = 1'b0;
        jump_req      = 1'b0;
        jump_target   = '0;
        branch_req    = 1'b0;
        branch_offset = '0;
        imem_ready    = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // 1: reset, boot cycle, then sequential fetch 0,2,...,38
        do_reset();
        chk("boot_pc_write", 32'(pc_write), 32'd0);
        chk("boot_imem_req", 32'(imem_req), 32'd0);
        chk("boot_flush", 32'(flush), 32'd0);
        chk("boot_pc", 32'(pc), 32'h0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("seq_pc", 32'(pc), 32'(2 * i));
            chk("seq_pc_write", 32'(pc_write), 32'd1);
            tick();
        end
        chk("seq_pc_final", 32'(pc), 32'd40);

        // 2: stall four cycles at PC=0x0010
        do_reset();
        tick();
        repeat (8) tick();
        chk("stall_start_pc", 32'(pc), 32'h10);
        stall = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_pc_write", 32'(pc_write), 32'd0);
            chk("stall_imem_req", 32'(imem_req), 32'd1);
            tick();
            chk("stall_pc_hold", 32'(pc), 32'h10);
        end
        stall = 1'b0;
        #1;
        chk("unstall_pc_write", 32'(pc_write), 32'd1);
        chk("seq_se_zero", 32'(pc_add_from_se), 32'd0);
        chk("seq_vala_zero", 32'(pc_source_from_vala), 32'd0);
        tick();
        chk("unstall_pc", 32'(pc), 32'h12);

        // 3: simultaneous jump and branch, jump wins, stall overridden
        jump_req      = 1'b1;
        jump_target   = 16'h0400;
        branch_req    = 1'b1;
        branch_offset = 16'h0006;
        stall         = 1'b1;
        #1;
        chk("jb_pc_write", 32'(pc_write), 32'd1);
        chk("jb_pc_source", 32'(pc_source), 32'd1);
        chk("jb_pc_add", 32'(pc_add), 32'd0);
        chk("jb_flush", 32'(flush), 32'd1);
        chk("jb_vala", 32'(pc_source_from_vala), 32'h0400);
        chk("jb_se", 32'(pc_add_from_se), 32'd0);
        tick();
        jump_req   = 1'b0;
        branch_req = 1'b0;
        stall      = 1'b0;
        chk("jb_pc", 32'(pc), 32'h0400);

        // 4: backward branch held by I-mem wait states, wraps modulo 2^16
        jump_req    = 1'b1;
        jump_target = 16'h0020;
        #1;
        tick();
        jump_req = 1'b0;
        chk("br_start_pc", 32'(pc), 32'h20);
        branch_req    = 1'b1;
        branch_offset = 16'hFFF0;
        imem_ready    = 1'b0;
        #1;
        chk("br_cap_pc_write", 32'(pc_write), 32'd0);
        chk("br_cap_flush", 32'(flush), 32'd0);
        chk("br_cap_pending", 32'(redir_pending), 32'd0);
        tick();
        branch_req    = 1'b0;
        branch_offset = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("br_pend", 32'(redir_pending), 32'd1);
            chk("br_pend_pc_write", 32'(pc_write), 32'd0);
            chk("br_pend_flush", 32'(flush), 32'd0);
            tick();
            chk("br_pend_pc", 32'(pc), 32'h20);
        end
        imem_ready = 1'b1;
        #1;
        chk("br_apply_pc_write", 32'(pc_write), 32'd1);
        chk("br_apply_pc_add", 32'(pc_add), 32'd1);
        chk("br_apply_pc_source", 32'(pc_source), 32'd0);
        chk("br_apply_flush", 32'(flush), 32'd1);
        chk("br_apply_se", 32'(pc_add_from_se), 32'hFFF0);
        tick();
        chk("br_apply_pc", 32'(pc), 32'h10);
        chk("br_after_pending", 32'(redir_pending), 32'd0);
        chk("br_after_flush", 32'(flush), 32'd0);

        // 5: branch arriving while a jump is pending is dropped
        jump_req    = 1'b1;
        jump_target = 16'h0100;
        imem_ready  = 1'b0;
        #1;
        tick();
        jump_req      = 1'b0;
        jump_target   = 16'h0BAD;
        branch_req    = 1'b1;
        branch_offset = 16'h0004;
        #1;
        chk("drop_pending", 32'(redir_pending), 32'd1);
        chk("drop_pc_write", 32'(pc_write), 32'd0);
        tick();
        branch_req = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("drop_apply_source", 32'(pc_source), 32'd1);
        chk("drop_apply_vala", 32'(pc_source_from_vala), 32'h0100);
        chk("drop_apply_flush", 32'(flush), 32'd1);
        tick();
        chk("drop_pc", 32'(pc), 32'h0100);
`ifdef PCSEQ_PERF_CNT_EN
        chk("drop_count", 32'(dropped_redir), 32'd1);
`endif
        tick();
        chk("drop_seq_pc", 32'(pc), 32'h0102);

        // 6: reset while a redirect is pending discards it
        jump_req    = 1'b1;
        jump_target = 16'h0200;
        imem_ready  = 1'b0;
        #1;
        tick();
        jump_req = 1'b0;
        chk("rp_pending", 32'(redir_pending), 32'd1);
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("rp_in_reset_pc_write", 32'(pc_write), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rp_boot_pending", 32'(redir_pending), 32'd0);
        chk("rp_boot_flush", 32'(flush), 32'd0);
        chk("rp_boot_imem_req", 32'(imem_req), 32'd0);
        chk("rp_boot_pc_write", 32'(pc_write), 32'd0);
        chk("rp_boot_pc", 32'(pc), 32'h0);
        tick();
        chk("rp_fetch_pc_write", 32'(pc_write), 32'd1);
        chk("rp_fetch_source", 32'(pc_source), 32'd0);
        chk("rp_fetch_flush", 32'(flush), 32'd0);
        tick();
        chk("rp_fetch_pc", 32'(pc), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
